// File: rtl/mult_pkg.sv
// Shared definitions for the multiplier-sharing scheduler: FSM states and
// default sizing, including the default timeout derived from operand width.
package mult_pkg;

    localparam int DEF_WIDTH   = 4;
    localparam int DEF_NUM_REQ = 4;

    // Worst-case multiplier latency plus slack; a slower op is abandoned.
    function automatic int timeout_default(input int width);
        return 2 * width + 8;
    endfunction

    typedef enum logic [2:0] {
        S_IDLE,
        S_ISSUE,
        S_WAIT,
        S_CAPT,
        S_RESP
    } state_e;

endpackage

// File: rtl/rr_arbiter.sv
// Combinational rotate-priority picker: returns the first set request bit
// found searching upward from last_grant+1 with wrap, plus an any-request flag.
module rr_arbiter #(
    parameter int N  = 4,
    parameter int IW = $clog2(N)
) (
    input  logic [N-1:0]  req,
    input  logic [IW-1:0] last_grant,
    output logic [IW-1:0] grant,
    output logic          any_req
);

    always_comb begin
        int  idx;
        logic found;
        grant = '0;
        found = 1'b0;
        idx   = 0;
        for (int k = 1; k <= N; k++) begin
            idx = int'(last_grant) + k;
            if (idx >= N) idx = idx - N;
            if (!found && req[idx]) begin
                found = 1'b1;
                grant = IW'(idx);
            end
        end
        any_req = |req;
    end

endmodule

// File: rtl/mult_share_arbiter.sv
// Round-robin scheduler sharing one sequential multiplier among NUM_REQ
// requesters; owns the multiplier's start pulse and operand buses.
//
// Handshake: a requester raises req[i] with stable operands and holds them
// until ack[i] pulses for one cycle; resp_product/resp_err are valid only in
// that ack cycle. A req still high in the following IDLE cycle is a new request.
module mult_share_arbiter
    import mult_pkg::*;
#(
    parameter int WIDTH   = DEF_WIDTH,
    parameter int NUM_REQ = DEF_NUM_REQ,
    parameter int TIMEOUT = timeout_default(DEF_WIDTH)
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [NUM_REQ-1:0]       req,
    input  logic [NUM_REQ*WIDTH-1:0] req_a,
    input  logic [NUM_REQ*WIDTH-1:0] req_b,
    output logic [NUM_REQ-1:0]       ack,
    output logic [2*WIDTH-1:0]       resp_product,
    output logic                     resp_err,
    output logic                     busy,
    output logic                     mul_start,
    output logic [WIDTH-1:0]         mul_md,
    output logic [WIDTH-1:0]         mul_mr,
    input  logic                     mul_done,
    input  logic [2*WIDTH-1:0]       mul_product
);

    localparam int IDXW = $clog2(NUM_REQ);
    localparam int CNTW = $clog2(TIMEOUT + 1);

    state_e               state_q, state_d;
    logic [IDXW-1:0]      grant_q, grant_d;
    logic [IDXW-1:0]      last_grant_q, last_grant_d;
    logic [WIDTH-1:0]     md_q, md_d;
    logic [WIDTH-1:0]     mr_q, mr_d;
    logic [CNTW-1:0]      cnt_q, cnt_d;
    logic                 err_q, err_d;
    logic [2*WIDTH-1:0]   product_q, product_d;

    logic [IDXW-1:0]      pick_idx;
    logic                 any_req;

    rr_arbiter #(.N(NUM_REQ), .IW(IDXW)) u_rr (
        .req        (req),
        .last_grant (last_grant_q),
        .grant      (pick_idx),
        .any_req    (any_req)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= S_IDLE;
            grant_q      <= '0;
            last_grant_q <= IDXW'(NUM_REQ - 1);
            md_q         <= '0;
            mr_q         <= '0;
            cnt_q        <= '0;
            err_q        <= 1'b0;
            product_q    <= '0;
        end else begin
            state_q      <= state_d;
            grant_q      <= grant_d;
            last_grant_q <= last_grant_d;
            md_q         <= md_d;
            mr_q         <= mr_d;
            cnt_q        <= cnt_d;
            err_q        <= err_d;
            product_q    <= product_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        grant_d      = grant_q;
        last_grant_d = last_grant_q;
        md_d         = md_q;
        mr_d         = mr_q;
        cnt_d        = cnt_q;
        err_d        = err_q;
        product_d    = product_q;
        unique case (state_q)
            S_IDLE: begin
                if (any_req) begin
                    grant_d      = pick_idx;
                    last_grant_d = pick_idx;
                    md_d         = req_a[int'(pick_idx) * WIDTH +: WIDTH];
                    mr_d         = req_b[int'(pick_idx) * WIDTH +: WIDTH];
                    state_d      = S_ISSUE;
                end
            end
            S_ISSUE: begin
                cnt_d   = '0;
                state_d = S_WAIT;
            end
            S_WAIT: begin
                cnt_d = cnt_q + CNTW'(1);
                // A done arriving on the timeout cycle still wins.
                if (mul_done) begin
                    state_d = S_CAPT;
                end else if (cnt_q == CNTW'(TIMEOUT)) begin
                    err_d     = 1'b1;
                    product_d = '0;
                    state_d   = S_RESP;
                end
            end
            S_CAPT: begin
                product_d = mul_product;
                state_d   = S_RESP;
            end
            S_RESP: begin
                err_d   = 1'b0;
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        for (int i = 0; i < NUM_REQ; i++) begin
            ack[i] = (state_q == S_RESP) && (grant_q == IDXW'(i));
        end
    end

    assign resp_product = product_q;
    assign resp_err     = (state_q == S_RESP) && err_q;
    assign busy         = (state_q != S_IDLE);
    assign mul_start    = (state_q == S_ISSUE);
    assign mul_md       = md_q;
    assign mul_mr       = mr_q;

endmodule
